// File: rtl/regfile.sv
// RV32I integer register file: x0 hardwired to zero, two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_rd_wren,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [15:0] o_wr_count
);

  logic [31:0] regs_q [32];
  logic [15:0] wr_count_q, wr_count_d;
  logic        commit;

  // Reset has async priority in the flops, so it need not gate commit here.
  assign commit = i_rd_wren && (i_rd_addr != 5'd0);

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
      regs_q[2]  <= SP_INIT;
      regs_q[3]  <= GP_INIT;
      wr_count_q <= 16'h0;
    end else begin
      if (commit) regs_q[i_rd_addr] <= i_rd_data;
      wr_count_q <= wr_count_d;
    end
  end

  // Entry 0 is never written, but reads of x0 are forced to zero explicitly.
  always_comb begin
    o_rs1_data = (i_rs1_addr == 5'd0) ? 32'h0 : regs_q[i_rs1_addr];
    o_rs2_data = (i_rs2_addr == 5'd0) ? 32'h0 : regs_q[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (commit && !i_reset && (i_rd_addr == i_rs1_addr)) o_rs1_data = i_rd_data;
    if (commit && !i_reset && (i_rd_addr == i_rs2_addr)) o_rs2_data = i_rd_data;
`endif
  end

  assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset values, writes, x0, read-during-write, reset abort, saturation.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rd_wren;
  logic [15:0] wr_count;

  int n_chk  = 0;
  int n_fail = 0;

  regfile dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .i_rd_wren  (rd_wren),
    .i_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rd_wren = 1'b1; rd_addr = a; rd_data = d;
    @(posedge clk); #1;
    rd_wren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_wren = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = 5'd2; rs2_addr = 5'd3;
    // Before the first clock edge at t=5
    #2;
    chk("rst_x2", rs1_data, 32'h0000_7FFC);
    chk("rst_x3", rs2_data, 32'h0000_1800);
    rs1_addr = 5'd5; #1;
    chk("rst_x5", rs1_data, 32'h0);
    chk("rst_cnt", {16'h0, wr_count}, 32'h0);
    @(negedge clk); rst = 1'b0;

    wr(5'd5, 32'hDEADBEEF);
    wr(5'd6, 32'h0000_0001);
    rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
    chk("rd_x5", rs1_data, 32'hDEADBEEF);
    chk("rd_x6", rs2_data, 32'h0000_0001);
    chk("cnt2", {16'h0, wr_count}, 32'd2);
    rs2_addr = 5'd5; #1;
    chk("dual_x5", rs2_data, 32'hDEADBEEF);

    wr(5'd0, 32'hFFFFFFFF);
    rs1_addr = 5'd0; #1;
    chk("x0_rd", rs1_data, 32'h0);
    chk("x0_cnt", {16'h0, wr_count}, 32'd2);

    // Read-during-write on x7
    @(negedge clk);
    rd_wren = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678; rs1_addr = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_pre", rs1_data, 32'h12345678);
`else
    chk("rdw_pre", rs1_data, 32'h0);
`endif
    @(posedge clk); #1;
    rd_wren = 1'b0; #1;
    chk("rdw_post", rs1_data, 32'h12345678);
    chk("cnt3", {16'h0, wr_count}, 32'd3);

    // Reset arrives mid-cycle with a write pending
    wr(5'd9, 32'hA5A5A5A5);
    rs1_addr = 5'd9; rs2_addr = 5'd2; #1;
    chk("x9_wr", rs1_data, 32'hA5A5A5A5);
    @(negedge clk);
    rd_wren = 1'b1; rd_addr = 5'd9; rd_data = 32'h1;
    #2 rst = 1'b1; #1;
    chk("rst_mid_x9", rs1_data, 32'h0);
    chk("rst_mid_x2", rs2_data, 32'h0000_7FFC);
    chk("rst_mid_cnt", {16'h0, wr_count}, 32'h0);
    @(posedge clk); #1;
    chk("rst_edge_x9", rs1_data, 32'h0);
    chk("rst_edge_cnt", {16'h0, wr_count}, 32'h0);
    rd_wren = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_rel_x9", rs1_data, 32'h0);

    // Saturation: 65534 writes, then 2 more
    @(negedge clk);
    rd_wren = 1'b1; rd_addr = 5'd10;
    for (int i = 0; i < 65534; i++) begin
      rd_data = i;
      @(posedge clk); #1;
    end
    rd_wren = 1'b0;
    chk("cnt_fffe", {16'h0, wr_count}, 32'h0000_FFFE);
    wr(5'd12, 32'h1111_1111);
    chk("cnt_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
    wr(5'd12, 32'h2222_2222);
    rs1_addr = 5'd12; rs2_addr = 5'd10; #1;
    chk("cnt_hold", {16'h0, wr_count}, 32'h0000_FFFF);
    chk("sat_x12", rs1_data, 32'h2222_2222);
    chk("sat_x10", rs2_data, 32'd65533);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
